// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_pkg
//  Description : Shared IF-stage constants and the load-controller state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package if_pkg;

    localparam int IF_DEPTH     = 1024;
    localparam int IF_ADDR_W    = 10;
    localparam int IF_DATA_W    = 32;
    localparam int IF_DRAIN_CYC = 4;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

endpackage : if_pkg
`default_nettype wire

// File: rtl/if_imem_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : if_imem_load_ctrl
//  Description : Loads a program image into instruction memory over valid/ready,
//                then releases fetch; supports drain-and-reload while running.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_imem_load_ctrl
    import if_pkg::*;
#(
    parameter int DEPTH     = IF_DEPTH,
    parameter int ADDR_W    = IF_ADDR_W,
    parameter int DATA_W    = IF_DATA_W,
    parameter int DRAIN_CYC = IF_DRAIN_CYC
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Load_Valid,
    input  logic [DATA_W-1:0] Load_Data,
    input  logic              Load_Last,
    output logic              Load_Ready,
    input  logic              Reload_Req,
    output logic              Imem_We,
    output logic [ADDR_W-1:0] Imem_Waddr,
    output logic [DATA_W-1:0] Imem_Wdata,
    output logic              Fetch_Enable,
    output logic              PC_Restart,
    output logic [ADDR_W:0]   Words_Loaded,
    output logic              Load_Overflow
);

    localparam int DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    localparam logic [ADDR_W:0]    c_last_addr = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [DRAIN_W-1:0] c_drain_end = DRAIN_W'(DRAIN_CYC - 1);

    state_t             r_state;
    logic [ADDR_W:0]    r_cnt;
    logic [DRAIN_W-1:0] r_drain;

    logic               w_xfer;
    logic [ADDR_W:0]    w_cnt_inc;

    // Load_Ready is only ever high in LOAD, so it alone qualifies a transfer.
    assign w_xfer    = Load_Valid & Load_Ready;
    assign w_cnt_inc = r_cnt + 1'b1;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state       <= ST_LOAD;
            r_cnt         <= '0;
            r_drain       <= '0;
            Load_Ready    <= 1'b0;
            Imem_We       <= 1'b0;
            Imem_Waddr    <= '0;
            Imem_Wdata    <= '0;
            Fetch_Enable  <= 1'b0;
            PC_Restart    <= 1'b0;
            Words_Loaded  <= '0;
            Load_Overflow <= 1'b0;
        end else begin
            Imem_We    <= 1'b0;
            PC_Restart <= 1'b0;
            case (r_state)
                ST_LOAD: begin
                    Load_Ready <= 1'b1;
                    if (w_xfer) begin
                        Imem_We    <= 1'b1;
                        Imem_Waddr <= r_cnt[ADDR_W-1:0];
                        Imem_Wdata <= Load_Data;
                        r_cnt      <= w_cnt_inc;
                        // A full memory ends the load even without Load_Last.
                        if (Load_Last || (r_cnt == c_last_addr)) begin
                            if (!Load_Last) begin
                                Load_Overflow <= 1'b1;
                            end
                            Words_Loaded <= w_cnt_inc;
                            Load_Ready   <= 1'b0;
                            PC_Restart   <= 1'b1;
                            r_state      <= ST_START;
                        end
                    end
                end
                ST_START: begin
                    Fetch_Enable <= 1'b1;
                    r_state      <= ST_RUN;
                end
                ST_RUN: begin
                    if (Reload_Req) begin
                        Fetch_Enable <= 1'b0;
                        r_drain      <= '0;
                        r_state      <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (r_drain == c_drain_end) begin
                        r_cnt         <= '0;
                        Load_Overflow <= 1'b0;
                        r_state       <= ST_LOAD;
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule : if_imem_load_ctrl
`default_nettype wire

// File: tb/tb_if_imem_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_imem_load_ctrl
//  Description : Randomized self-checking bench for the IF instruction-memory
//                load controller against a mode-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_imem_load_ctrl;

    localparam int DEPTH     = 1024;
    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 32;
    localparam int DRAIN_CYC = 4;

    localparam int M_LOAD  = 0;
    localparam int M_START = 1;
    localparam int M_RUN   = 2;
    localparam int M_DRAIN = 3;

    logic              Clk = 1'b0;
    logic              Reset_n;
    logic              Load_Valid;
    logic [DATA_W-1:0] Load_Data;
    logic              Load_Last;
    logic              Load_Ready;
    logic              Reload_Req;
    logic              Imem_We;
    logic [ADDR_W-1:0] Imem_Waddr;
    logic [DATA_W-1:0] Imem_Wdata;
    logic              Fetch_Enable;
    logic              PC_Restart;
    logic [ADDR_W:0]   Words_Loaded;
    logic              Load_Overflow;

    int errors = 0;
    int checks = 0;

    if_imem_load_ctrl #(
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .DRAIN_CYC (DRAIN_CYC)
    ) u_dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .Load_Valid    (Load_Valid),
        .Load_Data     (Load_Data),
        .Load_Last     (Load_Last),
        .Load_Ready    (Load_Ready),
        .Reload_Req    (Reload_Req),
        .Imem_We       (Imem_We),
        .Imem_Waddr    (Imem_Waddr),
        .Imem_Wdata    (Imem_Wdata),
        .Fetch_Enable  (Fetch_Enable),
        .PC_Restart    (PC_Restart),
        .Words_Loaded  (Words_Loaded),
        .Load_Overflow (Load_Overflow)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode of the controller plus the values the outputs must show.
    int          m_mode  = M_LOAD;
    int          m_cnt   = 0;
    int          m_wait  = 0;
    int          m_words = 0;
    int          m_waddr = 0;
    logic [31:0] m_wdata = '0;
    bit          m_ready = 1'b0;
    bit          m_we    = 1'b0;
    bit          m_ovf   = 1'b0;
    bit          m_fe    = 1'b0;
    bit          m_pcr   = 1'b0;
    bit          m_live  = 1'b0;

    initial begin : model
        int old_mode;
        forever begin
            @(posedge Clk);
            if (!Reset_n) begin
                m_mode = M_LOAD; m_cnt = 0; m_wait = 0; m_words = 0;
                m_waddr = 0; m_wdata = '0; m_ready = 1'b0; m_we = 1'b0; m_ovf = 1'b0;
            end else begin
                old_mode = m_mode;
                m_we     = 1'b0;
                case (m_mode)
                    M_LOAD: begin
                        if (m_ready && Load_Valid) begin
                            m_we    = 1'b1;
                            m_waddr = m_cnt;
                            m_wdata = Load_Data;
                            m_cnt   = m_cnt + 1;
                            if (Load_Last || m_cnt == DEPTH) begin
                                m_words = m_cnt;
                                if (!Load_Last) m_ovf = 1'b1;
                                m_mode = M_START;
                            end
                        end
                    end
                    M_START: m_mode = M_RUN;
                    M_RUN: begin
                        if (Reload_Req) begin
                            m_mode = M_DRAIN;
                            m_wait = DRAIN_CYC;
                        end
                    end
                    default: begin
                        m_wait = m_wait - 1;
                        if (m_wait == 0) begin
                            m_mode = M_LOAD;
                            m_cnt  = 0;
                            m_ovf  = 1'b0;
                        end
                    end
                endcase
                m_ready = (old_mode == M_LOAD) && (m_mode == M_LOAD);
            end
            m_fe   = Reset_n && (m_mode == M_RUN);
            m_pcr  = Reset_n && (m_mode == M_START) && m_we;
            m_live = 1'b1;
        end
    end

    int unsigned obs_addr[$];
    logic [31:0] obs_data[$];
    int          pcr_count = 0;

    initial begin : compare
        forever begin
            @(negedge Clk);
            if (m_live) begin
                chk("load_ready", 64'(Load_Ready), 64'(m_ready));
                chk("imem_we", 64'(Imem_We), 64'(m_we));
                if (m_we) begin
                    chk("imem_waddr", 64'(Imem_Waddr), 64'(m_waddr));
                    chk("imem_wdata", 64'(Imem_Wdata), 64'(m_wdata));
                end
                chk("fetch_enable", 64'(Fetch_Enable), 64'(m_fe));
                chk("pc_restart", 64'(PC_Restart), 64'(m_pcr));
                chk("words_loaded", 64'(Words_Loaded), 64'(m_words));
                chk("load_overflow", 64'(Load_Overflow), 64'(m_ovf));
                if (Imem_We) begin
                    obs_addr.push_back(int'(Imem_Waddr));
                    obs_data.push_back(Imem_Wdata);
                end
                if (PC_Restart) pcr_count++;
            end
        end
    end

    logic [31:0] t1_words [3] = '{32'h20080001, 32'h20090002, 32'h01095020};

    // mode 0: valid every cycle, 1: every other cycle, 2: random
    task automatic load_img(input int n, input bit use_last, input int mode, input bit fixed);
        int sent  = 0;
        int guard = 0;
        while (sent < n) begin
            @(negedge Clk);
            guard++;
            if (guard > 5000) begin
                checks++; errors++;
                $display("FAIL load_timeout: got %0d words expected %0d", sent, n);
                break;
            end
            case (mode)
                0:       Load_Valid = 1'b1;
                1:       Load_Valid = guard[0];
                default: Load_Valid = ($urandom_range(99) < 60);
            endcase
            Load_Data = fixed ? t1_words[sent] : $urandom;
            Load_Last = use_last && (sent == n - 1);
            if (Load_Valid && Load_Ready) sent++;
        end
        @(negedge Clk);
        Load_Valid = 1'b0;
        Load_Last  = 1'b0;
        Reload_Req = 1'b0;
    endtask

    task automatic wait_run();
        int n = 0;
        while (!Fetch_Enable) begin
            @(negedge Clk);
            n++;
            if (n > 50) begin
                checks++; errors++;
                $display("FAIL run_timeout: got fetch_enable 0 expected 1");
                break;
            end
        end
    endtask

    task automatic reload(output int lat);
        lat = 0;
        @(negedge Clk);
        Reload_Req = 1'b1;
        @(negedge Clk);
        Reload_Req = 1'b0;
        while (!Load_Ready) begin
            @(negedge Clk);
            lat++;
            if (lat > 50) begin
                checks++; errors++;
                $display("FAIL ready_timeout: got load_ready 0 expected 1");
                break;
            end
        end
    endtask

    initial begin : stim
        int lat;
        Reset_n = 1'b0; Load_Valid = 1'b0; Load_Data = '0; Load_Last = 1'b0; Reload_Req = 1'b0;
        repeat (3) @(negedge Clk);
        chk("rst_ready", 64'(Load_Ready), 64'd0);
        chk("rst_waddr", 64'(Imem_Waddr), 64'd0);
        chk("rst_wdata", 64'(Imem_Wdata), 64'd0);
        chk("rst_fetch", 64'(Fetch_Enable), 64'd0);
        chk("rst_words", 64'(Words_Loaded), 64'd0);
        Reset_n = 1'b1;

        // Three-word image with fixed contents
        obs_addr.delete(); obs_data.delete(); pcr_count = 0;
        load_img(3, 1'b1, 0, 1'b1);
        wait_run();
        @(negedge Clk);
        chk("t1_nwrites", 64'(obs_addr.size()), 64'd3);
        if (obs_addr.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("t1_addr", 64'(obs_addr[i]), 64'(i));
                chk("t1_data", 64'(obs_data[i]), 64'(t1_words[i]));
            end
        end
        chk("t1_pcr_pulses", 64'(pcr_count), 64'd1);
        chk("t1_words", 64'(Words_Loaded), 64'd3);
        chk("t1_model_words", 64'(m_words), 64'd3);

        // Gappy valid, then Load_Valid held in RUN
        reload(lat);
        load_img(10, 1'b1, 1, 1'b0);
        wait_run();
        obs_addr.delete(); obs_data.delete();
        Load_Valid = 1'b1;
        repeat (8) begin
            @(negedge Clk);
            Load_Data = $urandom;
        end
        Load_Valid = 1'b0;
        @(negedge Clk);
        chk("t6_run_writes", 64'(obs_addr.size()), 64'd0);

        // Overflow: full memory without Load_Last, extra words refused
        reload(lat);
        obs_addr.delete(); obs_data.delete();
        load_img(DEPTH, 1'b0, 2, 1'b0);
        Load_Valid = 1'b1;
        repeat (10) @(negedge Clk);
        Load_Valid = 1'b0;
        chk("t3_nwrites", 64'(obs_addr.size()), 64'(DEPTH));
        chk("t3_overflow", 64'(Load_Overflow), 64'd1);
        chk("t3_words", 64'(Words_Loaded), 64'd1024);
        wait_run();

        // Reload clears overflow and restarts at address 0
        reload(lat);
        chk("t4_drain_latency", 64'(lat), 64'd5);
        chk("t4_overflow_clr", 64'(Load_Overflow), 64'd0);
        obs_addr.delete(); obs_data.delete();
        load_img(6, 1'b1, 2, 1'b0);
        wait_run();
        chk("t4_first_addr", (obs_addr.size() > 0) ? 64'(obs_addr[0]) : 64'hdead, 64'd0);
        chk("t4_words", 64'(Words_Loaded), 64'd6);

        // Reset mid-load
        reload(lat);
        load_img(5, 1'b0, 0, 1'b0);
        Reset_n = 1'b0;
        repeat (2) @(negedge Clk);
        chk("t5_rst_ready", 64'(Load_Ready), 64'd0);
        chk("t5_rst_words", 64'(Words_Loaded), 64'd0);
        chk("t5_rst_we", 64'(Imem_We), 64'd0);
        chk("t5_rst_waddr", 64'(Imem_Waddr), 64'd0);
        Reset_n = 1'b1;
        obs_addr.delete(); obs_data.delete();
        load_img(4, 1'b1, 2, 1'b0);
        wait_run();
        chk("t5_first_addr", (obs_addr.size() > 0) ? 64'(obs_addr[0]) : 64'hdead, 64'd0);
        chk("t5_words", 64'(Words_Loaded), 64'd4);

        // Reload_Req held during load; random short images including single-word
        reload(lat);
        Reload_Req = 1'b1;
        load_img(3, 1'b1, 2, 1'b0);
        wait_run();
        for (int k = 0; k < 4; k++) begin
            reload(lat);
            load_img((k == 0) ? 1 : int'($urandom_range(20, 1)), 1'b1, 2, 1'b0);
            wait_run();
        end
        repeat (3) @(negedge Clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_if_imem_load_ctrl
`default_nettype wire
